// File: rtl/pong_shift_datapath.sv
// Ball-position datapath for the pong game: universal shift register holding a one-hot LED row,
// plus a saturating rally counter that counts entries into the controller's end state.
module pong_shift_datapath #(
    parameter int          WIDTH    = 8,
    parameter int unsigned LOAD_VAL = 0,
    parameter int          CNT_W    = 4,
    localparam int         POS_W    = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               ireset_n,
    input  logic [1:0]         s,
    input  logic               lsi,
    input  logic               rsi,
    output logic [WIDTH-1:0]   leds,
    output logic               qleft,
    output logic               qright,
    output logic [POS_W-1:0]   pos,
    output logic               pos_valid,
    output logic [CNT_W-1:0]   rally_cnt,
    output logic               rally_sat
);

    localparam logic [1:0]       S_HOLD  = 2'b00;
    localparam logic [1:0]       S_RIGHT = 2'b01;
    localparam logic [1:0]       S_LEFT  = 2'b10;
    localparam logic [1:0]       S_LOAD  = 2'b11;
    localparam logic [WIDTH-1:0] LOAD_W  = WIDTH'(LOAD_VAL);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] leds_r;
    logic [WIDTH-1:0] leds_nxt_s;
    logic [1:0]       prev_s_r;
    logic [CNT_W-1:0] rally_cnt_r;
    logic             end_evt_s;
    logic             sat_s;
    logic [POS_W-1:0] pos_s;
    logic             onehot_s;

    // Next shift-register value selected by the controller's mode
    always_comb begin
        leds_nxt_s = leds_r;
        case (s)
            S_HOLD:  leds_nxt_s = leds_r;
            S_RIGHT: leds_nxt_s = {rsi, leds_r[WIDTH-1:1]};
            S_LEFT:  leds_nxt_s = {leds_r[WIDTH-2:0], lsi};
            S_LOAD:  leds_nxt_s = LOAD_W;
            default: leds_nxt_s = leds_r;
        endcase
    end

    // Shift register state; bits leaving either end are dropped
    always_ff @(posedge clk or negedge ireset_n) begin
        if (!ireset_n) begin
            leds_r <= {WIDTH{1'b0}};
        end else begin
            leds_r <= leds_nxt_s;
        end
    end

    // An end event is the first edge of a run of hold cycles
    always_comb begin
        sat_s = (rally_cnt_r == CNT_MAX);
        if ((s == S_HOLD) && (prev_s_r != S_HOLD)) begin
            end_evt_s = 1'b1;
        end else begin
            end_evt_s = 1'b0;
        end
    end

    // Previous mode and saturating rally counter; reset is the only clear
    always_ff @(posedge clk or negedge ireset_n) begin
        if (!ireset_n) begin
            prev_s_r    <= S_LOAD;
            rally_cnt_r <= {CNT_W{1'b0}};
        end else begin
            prev_s_r <= s;
            if (end_evt_s && !sat_s) begin
                rally_cnt_r <= rally_cnt_r + CNT_W'(1);
            end else begin
                rally_cnt_r <= rally_cnt_r;
            end
        end
    end

    // Lowest set bit wins; scanning downward lets the lowest index overwrite
    always_comb begin
        pos_s = {POS_W{1'b0}};
        for (int i = WIDTH - 1; i >= 0; i--) begin
            pos_s = leds_r[i] ? POS_W'(i) : pos_s;
        end
    end

    // Exactly one bit set: nonzero and clearing the lowest bit leaves nothing
    always_comb begin
        if (leds_r != {WIDTH{1'b0}}) begin
            onehot_s = ((leds_r & (leds_r - WIDTH'(1))) == {WIDTH{1'b0}});
        end else begin
            onehot_s = 1'b0;
        end
    end

    assign leds      = leds_r;
    assign qleft     = leds_r[WIDTH-1];
    assign qright    = leds_r[0];
    assign pos       = pos_s;
    assign pos_valid = onehot_s;
    assign rally_cnt = rally_cnt_r;
    assign rally_sat = sat_s;

endmodule

// File: tb/tb_pong_shift_datapath.sv
// Self-checking bench for pong_shift_datapath: table-driven game sequence, scoreboard queue of
// expected results, and hand-written reset/saturation/random sequences against a small model.
module tb_pong_shift_datapath;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             ireset_n;
    logic [1:0]       s;
    logic             lsi;
    logic             rsi;
    logic [WIDTH-1:0] leds;
    logic             qleft;
    logic             qright;
    logic [2:0]       pos;
    logic             pos_valid;
    logic [CNT_W-1:0] rally_cnt;
    logic             rally_sat;

    pong_shift_datapath #(.WIDTH(WIDTH), .LOAD_VAL(0), .CNT_W(CNT_W)) dut (
        .clk(clk), .ireset_n(ireset_n), .s(s), .lsi(lsi), .rsi(rsi),
        .leds(leds), .qleft(qleft), .qright(qright), .pos(pos), .pos_valid(pos_valid),
        .rally_cnt(rally_cnt), .rally_sat(rally_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] s;
        logic       lsi;
        logic       rsi;
        logic [7:0] leds;
        logic [3:0] cnt;
    } vec_t;

    typedef struct {
        logic [7:0] leds;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];
    vec_t tab[$];
    int   checks = 0;
    int   passes = 0;

    logic [7:0] m_leds;
    logic [1:0] m_prev;
    logic [3:0] m_cnt;

    function automatic int low_pos(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic one_hot(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) if (v[i]) n++;
        return (n == 1);
    endfunction

    task automatic check(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s %s: got %0h expected %0h", tag, what, act, exp);
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] el, input logic [3:0] ec);
        check(tag, "leds", 32'(leds), 32'(el));
        check(tag, "qleft", 32'(qleft), 32'(el[7]));
        check(tag, "qright", 32'(qright), 32'(el[0]));
        check(tag, "pos", 32'(pos), 32'(low_pos(el)));
        check(tag, "pos_valid", 32'(pos_valid), 32'(one_hot(el)));
        check(tag, "rally_cnt", 32'(rally_cnt), 32'(ec));
        check(tag, "rally_sat", 32'(rally_sat), 32'(ec == 4'd15));
    endtask

    task automatic model_apply(input logic [1:0] sv, input logic l, input logic r);
        if (sv == 2'b00 && m_prev != 2'b00 && m_cnt != 4'd15) m_cnt = m_cnt + 4'd1;
        case (sv)
            2'b01:   m_leds = {r, m_leds[7:1]};
            2'b10:   m_leds = {m_leds[6:0], l};
            2'b11:   m_leds = 8'h00;
            default: m_leds = m_leds;
        endcase
        m_prev = sv;
    endtask

    // Drive one cycle; expected value comes from the table when given, else from the model
    task automatic step(input logic [1:0] sv, input logic l, input logic r,
                        input bit use_tab, input logic [7:0] tl, input logic [3:0] tc, input string tag);
        exp_t e;
        @(negedge clk);
        s = sv; lsi = l; rsi = r;
        model_apply(sv, l, r);
        e.leds = use_tab ? tl : m_leds;
        e.cnt  = use_tab ? tc : m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            $display("FAIL %s scoreboard: got empty expected entry", tag);
        end else begin
            e = sb.pop_front();
            check_outputs(tag, e.leds, e.cnt);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        ireset_n = 1'b0; s = 2'b11; lsi = 1'b0; rsi = 1'b0;
        #2;
        check_outputs(tag, 8'h00, 4'd0);
        @(negedge clk);
        ireset_n = 1'b1;
        m_leds = 8'h00; m_prev = 2'b11; m_cnt = 4'd0;
    endtask

    function automatic vec_t mk(input logic [1:0] sv, input logic l, input logic r,
                                input logic [7:0] el, input logic [3:0] ec);
        vec_t v;
        v.s = sv; v.lsi = l; v.rsi = r; v.leds = el; v.cnt = ec;
        return v;
    endfunction

    initial begin
        // Serve, walk the ball left, fall off, end state, idle, then right-shift corner case
        tab.push_back(mk(2'b11, 1'b0, 1'b0, 8'h00, 4'd0));
        tab.push_back(mk(2'b10, 1'b1, 1'b0, 8'h01, 4'd0));
        tab.push_back(mk(2'b10, 1'b0, 1'b0, 8'h02, 4'd0));
        tab.push_back(mk(2'b10, 1'b0, 1'b0, 8'h04, 4'd0));
        tab.push_back(mk(2'b10, 1'b0, 1'b0, 8'h08, 4'd0));
        tab.push_back(mk(2'b10, 1'b0, 1'b0, 8'h10, 4'd0));
        tab.push_back(mk(2'b10, 1'b0, 1'b0, 8'h20, 4'd0));
        tab.push_back(mk(2'b10, 1'b0, 1'b0, 8'h40, 4'd0));
        tab.push_back(mk(2'b10, 1'b0, 1'b0, 8'h80, 4'd0));
        tab.push_back(mk(2'b10, 1'b0, 1'b0, 8'h00, 4'd0));
        tab.push_back(mk(2'b00, 1'b0, 1'b0, 8'h00, 4'd1));
        tab.push_back(mk(2'b00, 1'b0, 1'b0, 8'h00, 4'd1));
        tab.push_back(mk(2'b00, 1'b0, 1'b0, 8'h00, 4'd1));
        tab.push_back(mk(2'b11, 1'b0, 1'b0, 8'h00, 4'd1));
        tab.push_back(mk(2'b10, 1'b1, 1'b0, 8'h01, 4'd1));
        tab.push_back(mk(2'b01, 1'b0, 1'b1, 8'h80, 4'd1));
        tab.push_back(mk(2'b01, 1'b0, 1'b1, 8'hC0, 4'd1));
        tab.push_back(mk(2'b00, 1'b0, 1'b0, 8'hC0, 4'd2));
        tab.push_back(mk(2'b00, 1'b0, 1'b0, 8'hC0, 4'd2));
        tab.push_back(mk(2'b11, 1'b0, 1'b0, 8'h00, 4'd2));

        ireset_n = 1'b0; s = 2'b11; lsi = 1'b0; rsi = 1'b0;
        m_leds = 8'h00; m_prev = 2'b11; m_cnt = 4'd0;
        #12;
        check_outputs("reset", 8'h00, 4'd0);
        @(negedge clk);
        ireset_n = 1'b1;

        foreach (tab[i]) step(tab[i].s, tab[i].lsi, tab[i].rsi, 1'b1, tab[i].leds, tab[i].cnt,
                              $sformatf("vec%0d", i));

        // Saturation: 17 end events from a fresh count
        do_reset("reset_sat");
        for (int i = 0; i < 17; i++) begin
            step(2'b10, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, "sat_move");
            step(2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, $sformatf("sat_end%0d", i + 1));
        end
        check("sat_final", "rally_cnt", 32'(rally_cnt), 32'd15);
        step(2'b11, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, "sat_idle_keeps");

        // Random mode/serial activity against the model
        for (int i = 0; i < 60; i++) begin
            step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'b0, 8'h00, 4'd0, $sformatf("rnd%0d", i));
        end

        // Mid-game asynchronous reset with leds = 00010000, rally_cnt = 3
        do_reset("reset_pre_mid");
        for (int i = 0; i < 3; i++) begin
            step(2'b10, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, "mid_move");
            step(2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, "mid_end");
        end
        step(2'b11, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, "mid_idle");
        step(2'b10, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, "mid_serve");
        for (int i = 0; i < 4; i++) step(2'b10, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, "mid_shift");
        check("mid_setup", "leds", 32'(leds), 32'h10);
        check("mid_setup", "rally_cnt", 32'(rally_cnt), 32'd3);
        #2;
        ireset_n = 1'b0;
        #1;
        check_outputs("mid_reset", 8'h00, 4'd0);
        @(negedge clk);
        ireset_n = 1'b1;
        m_leds = 8'h00; m_prev = 2'b11; m_cnt = 4'd0;
        step(2'b00, 1'b0, 1'b0, 1'b1, 8'h00, 4'd1, "post_reset_end");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pong_shift_datapath.md
Name: pong_shift_datapath

Overview:
- Ball-position datapath for the lab 8 pong game; sits directly downstream of pong_controller1.
- Consumes the controller's mode select s[1:0] and serial input lsi, and holds the ball as a one-hot LED row in a universal shift register.
- Returns qleft (leftmost LED) to the controller.
- Also counts completed rallies (controller end-state entries) and provides the binary ball position for display.

Parameters:
- WIDTH, 8, LED row length / shift register width (2..16).
- LOAD_VAL, 0, value parallel-loaded when s = 2'b11 (idle); must fit in WIDTH bits.
- CNT_W, 4, width of the rally counter.

Ports:
- clk, input, 1, system clock, rising-edge active.
- ireset_n, input, 1, asynchronous active-low reset.
- s, input, 2, mode select from controller: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- lsi, input, 1, serial in for shift left, entering bit 0.
- rsi, input, 1, serial in for shift right, entering bit WIDTH-1; tie 0 when unused.
- leds, output, WIDTH, shift register contents, driven to the LED row.
- qleft, output, 1, leds[WIDTH-1]; combinational from the register.
- qright, output, 1, leds[0].
- pos, output, clog2(WIDTH), index of the lowest set bit of leds; 0 when leds == 0.
- pos_valid, output, 1, high when leds has exactly one bit set.
- rally_cnt, output, CNT_W, number of end events since reset; saturating.
- rally_sat, output, 1, high when rally_cnt is all ones.

Behaviour:
- Reset (ireset_n low, asynchronous, takes effect immediately regardless of clk):
  - leds = 0, rally_cnt = 0, prev_s register = 2'b11.
  - Derived outputs therefore read qleft = 0, qright = 0, pos = 0, pos_valid = 0, rally_sat = 0.
- Reset deassertion: the first update happens on the first rising edge with ireset_n high.
- Shift register updates on every rising edge (no enable), from the value of s at that edge:
  - 00: leds holds.
  - 01: leds <= {rsi, leds[WIDTH-1:1]}.
  - 10: leds <= {leds[WIDTH-2:0], lsi}.
  - 11: leds <= LOAD_VAL.
- Latency:
  - One cycle from s/lsi to leds.
  - qleft, qright, pos and pos_valid are combinational from leds (zero added latency).
  - qleft is sampled by the controller on the same edge that updates leds.
- Bits shifted out of either end are discarded; there is no wrap-around.
  - Under sustained shift left with lsi = 0, leds reaches all zeros after WIDTH shifts.
- End-event detection:
  - prev_s <= s every edge.
  - An end event is s == 2'b00 and prev_s != 2'b00, evaluated at the edge.
  - Each end event increments rally_cnt by 1.
  - rally_cnt saturates at 2^CNT_W - 1; further events leave it unchanged and rally_sat stays high.
- Repeated cycles with s == 00 count once; a new count requires leaving 00 and re-entering it.
- rally_cnt is cleared only by ireset_n; s = 11 (controller idle) does not clear it.
- pos priority: the lowest set bit wins. pos_valid flags the illegal multi-bit and zero cases; no error correction is performed.
- Expected game sequence with the controller, WIDTH = 8:
  - Idle: leds = 00000000.
  - Serve edge: leds = 00000001.
  - Seven further shift edges: leds = 10000000, qleft = 1.
  - Next edge (controller still in move): leds = 00000000.
  - Controller end state (s = 00): rally_cnt increments.
  - Back to idle: leds reloaded to LOAD_VAL.
- Reset mid-game: leds and rally_cnt clear immediately; no partial count is recorded.

Test Plan:
1. Assert ireset_n low mid-clock with leds = 00010000 and rally_cnt = 3 -> leds = 0, rally_cnt = 0, pos_valid = 0 before the next edge.
2. s = 11 for 1 cycle, then s = 10 with lsi = 1 for 1 cycle, then s = 10 with lsi = 0 for 7 cycles -> leds steps 00000001..10000000; pos counts 0..7 with pos_valid = 1; qleft = 1 only after the 8th edge.
3. Continue with s = 10, lsi = 0 for one more edge, then s = 00 for 3 cycles -> leds = 00000000, rally_cnt increments exactly once (0 -> 1).
4. Run 17 end events (s toggling 10 -> 00) with CNT_W = 4 -> rally_cnt reaches 15 and stays 15; rally_sat = 1 from the 15th event onward.
5. leds = 00000001, s = 01 with rsi = 1 for 2 edges -> leds = 11000000 then holds under s = 00; pos = 6, pos_valid = 0.
6. Hook up pong_controller1: pulse irsrv for one cycle, no ireset -> full serve/move/end/idle loop reproduces the leds sequence of scenario 2/3, and rally_cnt = 1 when the controller returns to idle.
